tile_frame_sequencer: RTL and testbench

- Parametrised successor to the fixed 11x11 stage/player draw path.
- Holds a writable tile map and walks it row-major each frame, issuing one copy request per tile and then one per live player, each with its screen base coordinate and graphic code.
- Sits between the game FSM and the copy/blit engine. The copy engine adds the per-pixel offset; this block only sequences draw items and their bases.

---
 rtl/tile_frame_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_tile_frame_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_frame_sequencer.sv
// tile_frame_sequencer: walks a writable tile map row-major once per frame,
// issuing one copy request per tile and then one per live player sprite.
// Each request carries its screen base coordinate and graphic code; the copy
// engine downstream adds the per-pixel offset.
//
// Optional build macro: TILE_FRAME_SEQUENCER_DIRTY_EN
//   Adds one dirty bit per tile so that only tiles written since their last
//   draw are re-requested. Players are always drawn. Without the macro every
//   tile is drawn every frame and no dirty storage exists.
//
// Handshake: copy_req is a level. While copy_req=1 the item outputs are held
// (tile items) or follow the live player position (sprite items). The item is
// complete on the first cycle with copy_req=1 and copy_done=1. copy_done is
// ignored whenever copy_req=0.
module tile_frame_sequencer #(
    parameter int MAP_W       = 11,
    parameter int MAP_H       = 11,
    parameter int ADDR_W      = 7,
    parameter int TILE_LOG2   = 4,
    parameter int ORIGIN_X    = 72,
    parameter int ORIGIN_Y    = 32,
    parameter int N_PLAYERS   = 2,
    parameter int PLAYER_CODE = 8,
    parameter int XW          = 9,
    parameter int YW          = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    input  logic                    map_we,
    input  logic [ADDR_W-1:0]       map_addr,
    input  logic [3:0]              map_wdata,
    input  logic [N_PLAYERS*XW-1:0] player_x,
    input  logic [N_PLAYERS*YW-1:0] player_y,
    input  logic [N_PLAYERS-1:0]    player_alive,
    output logic                    copy_req,
    input  logic                    copy_done,
    output logic [3:0]              copy_code,
    output logic [XW-1:0]           base_x,
    output logic [YW-1:0]           base_y,
    output logic                    is_sprite,
    output logic [2:0]              dbg_state_o
);

    localparam int MAP_N = MAP_W * MAP_H;
    localparam int TXW   = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int TYW   = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int IW    = (MAP_N > 1) ? $clog2(MAP_N) : 1;
    localparam int PW    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    localparam logic [TXW-1:0] TX_LAST = TXW'(MAP_W - 1);
    localparam logic [TYW-1:0] TY_LAST = TYW'(MAP_H - 1);
    localparam logic [PW-1:0]  PL_LAST = PW'(N_PLAYERS - 1);
    localparam logic [3:0]     PCODE   = 4'(PLAYER_CODE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TILE      = 3'd1,
        S_TILE_NEXT = 3'd2,
        S_PLYR      = 3'd3,
        S_PLYR_NEXT = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [TXW-1:0] tx_q, tx_d;
    logic [TYW-1:0] ty_q, ty_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [PW-1:0]  pl_q, pl_d;
    logic [3:0]     tile_code_q;
    logic [3:0]     map_q [MAP_N];

    logic           map_wr_ok;
    logic           tile_live;
    logic [XW-1:0]  tile_bx;
    logic [YW-1:0]  tile_by;

    assign dbg_state_o = state_q;

    // Writes outside the map range are dropped rather than aliased.
    assign map_wr_ok = map_we && (32'(map_addr) < 32'(MAP_N));

    // Tile screen bases wrap naturally at the coordinate widths.
    assign tile_bx = XW'(ORIGIN_X) + (XW'(tx_q) << TILE_LOG2);
    assign tile_by = YW'(ORIGIN_Y) + (YW'(ty_q) << TILE_LOG2);

`ifdef TILE_FRAME_SEQUENCER_DIRTY_EN
    logic [MAP_N-1:0] dirty_q;
    logic             tile_done;

    assign tile_live = dirty_q[idx_q];
    assign tile_done = (state_q == S_TILE) && tile_live && copy_done;

    // Dirty bits: all set at reset, cleared when their draw completes, and
    // re-set by a write; the write is applied last so it wins a same-cycle tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dirty_q <= '1;
        end else begin
            if (tile_done) dirty_q[idx_q] <= 1'b0;
            if (map_wr_ok) dirty_q[IW'(map_addr)] <= 1'b1;
        end
    end
`else
    assign tile_live = 1'b1;
`endif

    // Tile map storage, cleared at reset and writable at any time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAP_N; k++) map_q[k] <= 4'd0;
        end else if (map_wr_ok) begin
            map_q[IW'(map_addr)] <= map_wdata;
        end
    end

    // State and walk pointers; the tile code is captured on entry to TILE so
    // it stays stable for the whole request even if that tile is rewritten.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tx_q        <= '0;
            ty_q        <= '0;
            idx_q       <= '0;
            pl_q        <= '0;
            tile_code_q <= 4'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            idx_q   <= idx_d;
            pl_q    <= pl_d;
            if (state_d == S_TILE && state_q != S_TILE) begin
                tile_code_q <= map_q[idx_d];
            end
        end
    end

    // Next-state, pointer update and item outputs.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        idx_d      = idx_q;
        pl_d       = pl_q;
        busy       = (state_q != S_IDLE);
        frame_done = 1'b0;
        copy_req   = 1'b0;
        copy_code  = 4'd0;
        base_x     = '0;
        base_y     = '0;
        is_sprite  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_TILE;
                    tx_d    = '0;
                    ty_d    = '0;
                    idx_d   = '0;
                end
            end

            S_TILE: begin
                if (tile_live) begin
                    copy_req  = 1'b1;
                    copy_code = tile_code_q;
                    base_x    = tile_bx;
                    base_y    = tile_by;
                    if (copy_done) state_d = S_TILE_NEXT;
                end else begin
                    state_d = S_TILE_NEXT;
                end
            end

            S_TILE_NEXT: begin
                if (tx_q == TX_LAST && ty_q == TY_LAST) begin
                    state_d = S_PLYR;
                    pl_d    = '0;
                end else begin
                    state_d = S_TILE;
                    idx_d   = idx_q + 1'b1;
                    if (tx_q == TX_LAST) begin
                        tx_d = '0;
                        ty_d = ty_q + 1'b1;
                    end else begin
                        tx_d = tx_q + 1'b1;
                    end
                end
            end

            S_PLYR: begin
                if (player_alive[pl_q]) begin
                    copy_req  = 1'b1;
                    is_sprite = 1'b1;
                    copy_code = PCODE + 4'(pl_q);
                    base_x    = player_x[pl_q*XW +: XW];
                    base_y    = player_y[pl_q*YW +: YW];
                    if (copy_done) state_d = S_PLYR_NEXT;
                end else begin
                    state_d = S_PLYR_NEXT;
                end
            end

            S_PLYR_NEXT: begin
                if (pl_q == PL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pl_d    = pl_q + 1'b1;
                    state_d = S_PLYR;
                end
            end

            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tile_frame_sequencer.sv
// Directed bench for tile_frame_sequencer: a default 11x11 instance and a
// 3x2 single-player instance share clock and reset.
module tb_tile_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // default instance
    logic        start = 1'b0;
    logic        busy, frame_done;
    logic        map_we = 1'b0;
    logic [6:0]  map_addr = '0;
    logic [3:0]  map_wdata = '0;
    logic [17:0] player_x = '0;
    logic [15:0] player_y = '0;
    logic [1:0]  player_alive = 2'b11;
    logic        copy_req, is_sprite;
    logic        copy_done = 1'b1;
    logic [3:0]  copy_code;
    logic [8:0]  base_x;
    logic [7:0]  base_y;
    logic [2:0]  dbg1;

    // 3x2 instance
    logic        s_start = 1'b0;
    logic        s_busy, s_frame_done;
    logic        s_map_we = 1'b0;
    logic [2:0]  s_map_addr = '0;
    logic [3:0]  s_map_wdata = '0;
    logic [8:0]  s_player_x = 9'd300;
    logic [7:0]  s_player_y = 8'd200;
    logic [0:0]  s_player_alive = 1'b1;
    logic        s_copy_req, s_is_sprite;
    logic        s_copy_done = 1'b1;
    logic [3:0]  s_copy_code;
    logic [8:0]  s_base_x;
    logic [7:0]  s_base_y;
    logic [2:0]  dbg2;

    int tests = 0;
    int fails = 0;

    // per-frame observations
    logic [3:0] r_code[$];
    logic [8:0] r_bx[$];
    logic [7:0] r_by[$];
    int  f_cycles, f_tiles, f_sprites, f_busy_low;
    bit  f_done;

    tile_frame_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy),
        .frame_done(frame_done), .map_we(map_we), .map_addr(map_addr),
        .map_wdata(map_wdata), .player_x(player_x), .player_y(player_y),
        .player_alive(player_alive), .copy_req(copy_req), .copy_done(copy_done),
        .copy_code(copy_code), .base_x(base_x), .base_y(base_y),
        .is_sprite(is_sprite), .dbg_state_o(dbg1)
    );

    tile_frame_sequencer #(.MAP_W(3), .MAP_H(2), .ADDR_W(3), .N_PLAYERS(1)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .busy(s_busy),
        .frame_done(s_frame_done), .map_we(s_map_we), .map_addr(s_map_addr),
        .map_wdata(s_map_wdata), .player_x(s_player_x), .player_y(s_player_y),
        .player_alive(s_player_alive), .copy_req(s_copy_req), .copy_done(s_copy_done),
        .copy_code(s_copy_code), .base_x(s_base_x), .base_y(s_base_y),
        .is_sprite(s_is_sprite), .dbg_state_o(dbg2)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic do_reset();
        start = 1'b0; map_we = 1'b0; copy_done = 1'b1;
        s_start = 1'b0; s_map_we = 1'b0; s_copy_done = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // driver tasks
    task automatic write_map(input logic [6:0] a, input logic [3:0] d);
        @(negedge clock);
        map_we = 1'b1; map_addr = a; map_wdata = d;
        @(negedge clock);
        map_we = 1'b0;
    endtask

    task automatic write_small(input logic [2:0] a, input logic [3:0] d);
        @(negedge clock);
        s_map_we = 1'b1; s_map_addr = a; s_map_wdata = d;
        @(negedge clock);
        s_map_we = 1'b0;
    endtask

    task automatic clear_frame();
        r_code.delete(); r_bx.delete(); r_by.delete();
        f_cycles = 0; f_tiles = 0; f_sprites = 0; f_busy_low = 0; f_done = 0;
    endtask

    // Observes the default instance until frame_done or a cycle budget runs
    // out. Cycle 1 is the cycle in which start is driven.
    task automatic collect_frame(input int cyc_start, input logic prev_in);
        int   cyc;
        logic prev;
        cyc  = cyc_start;
        prev = prev_in;
        while (!f_done && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (copy_req && !prev) begin
                r_code.push_back(copy_code);
                r_bx.push_back(base_x);
                r_by.push_back(base_y);
                if (is_sprite) f_sprites++; else f_tiles++;
            end
            prev = copy_req;
            if (!busy) f_busy_low++;
            if (frame_done) f_done = 1;
        end
        f_cycles = cyc;
        if (!f_done) begin
            tests++; fails++;
            $display("FAIL frame_timeout: no frame_done within %0d cycles", cyc);
        end
    endtask

    task automatic run_frame();
        clear_frame();
        @(negedge clock);
        start = 1'b1;
        collect_frame(1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, frame_done, copy_req, copy_code, base_x, base_y, is_sprite} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b code=%h bx=%0d by=%0d spr=%b required all 0",
                     busy, frame_done, copy_req, copy_code, base_x, base_y, is_sprite);
        end
        tests++;
        if ({s_busy, s_frame_done, s_copy_req, s_copy_code, s_base_x, s_base_y, s_is_sprite} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_small: got req=%b code=%h bx=%0d by=%0d required all 0",
                     s_copy_req, s_copy_code, s_base_x, s_base_y);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        player_alive = 2'b11;
        player_x = {9'd200, 9'd100};
        player_y = {8'd60, 8'd50};
        write_map(7'd12, 4'h3);
        run_frame();
        tests++;
        if (f_tiles !== 121) begin fails++; $display("FAIL full_tile_count: got %0d required 121", f_tiles); end
        tests++;
        if ({r_code[0], r_bx[0], r_by[0]} !== {4'h0, 9'd72, 8'd32}) begin
            fails++; $display("FAIL full_tile0: got code=%h bx=%0d by=%0d required 0 72 32", r_code[0], r_bx[0], r_by[0]);
        end
        tests++;
        if ({r_code[12], r_bx[12], r_by[12]} !== {4'h3, 9'd88, 8'd48}) begin
            fails++; $display("FAIL full_tile12: got code=%h bx=%0d by=%0d required 3 88 48", r_code[12], r_bx[12], r_by[12]);
        end
        tests++;
        if ({r_bx[120], r_by[120]} !== {9'd232, 8'd192}) begin
            fails++; $display("FAIL full_last_tile: got bx=%0d by=%0d required 232 192", r_bx[120], r_by[120]);
        end
        tests++;
        if (f_sprites !== 2) begin fails++; $display("FAIL full_sprite_count: got %0d required 2", f_sprites); end
        tests++;
        if ({r_code[121], r_bx[121], r_by[121], r_code[122], r_bx[122], r_by[122]} !==
            {4'h8, 9'd100, 8'd50, 4'h9, 9'd200, 8'd60}) begin
            fails++; $display("FAIL full_sprites: got %h/%0d/%0d %h/%0d/%0d required 8/100/50 9/200/60",
                              r_code[121], r_bx[121], r_by[121], r_code[122], r_bx[122], r_by[122]);
        end
        tests++;
        if (f_cycles !== 248) begin fails++; $display("FAIL full_frame_length: got %0d required 248", f_cycles); end
        tests++;
        if (f_busy_low !== 0) begin fails++; $display("FAIL full_busy: busy low %0d cycles in frame required 0", f_busy_low); end
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_dead_player();
        player_alive = 2'b10;
        player_x = {9'd232, 9'd72};
        player_y = {8'd96, 8'd96};
        run_frame();
        tests++;
        if (f_sprites !== 1) begin fails++; $display("FAIL dead_sprite_count: got %0d required 1", f_sprites); end
        tests++;
        if ({r_code[f_tiles], r_bx[f_tiles], r_by[f_tiles]} !== {4'h9, 9'd232, 8'd96}) begin
            fails++; $display("FAIL dead_sprite: got code=%h bx=%0d by=%0d required 9 232 96",
                              r_code[f_tiles], r_bx[f_tiles], r_by[f_tiles]);
        end
        tests++;
        if (f_cycles !== 248) begin fails++; $display("FAIL dead_frame_length: got %0d required 248", f_cycles); end
        player_alive = 2'b11;
    endtask

    task automatic test_stall();
        do_reset();
        write_map(7'd0, 4'hA);
        clear_frame();
        @(negedge clock);
        start = 1'b1;
        copy_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            tests++;
            if ({copy_req, is_sprite, copy_code, base_x, base_y} !== {1'b1, 1'b0, 4'hA, 9'd72, 8'd32}) begin
                fails++; $display("FAIL stall_hold[%0d]: got req=%b spr=%b code=%h bx=%0d by=%0d required 1 0 a 72 32",
                                  k, copy_req, is_sprite, copy_code, base_x, base_y);
            end
            start = (k == 1 || k == 3);
        end
        @(negedge clock);
        start = 1'b0;
        r_code.push_back(copy_code); r_bx.push_back(base_x); r_by.push_back(base_y);
        f_tiles = copy_req ? 1 : 0;
        copy_done = 1'b1;
        collect_frame(7, copy_req);
        tests++;
        if (f_tiles !== 121) begin fails++; $display("FAIL stall_tile_count: got %0d required 121", f_tiles); end
        tests++;
        if (f_cycles !== 253) begin fails++; $display("FAIL stall_frame_length: got %0d required 253", f_cycles); end
        repeat (3) @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL stall_start_dropped: busy got %b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int  waited;
        bit  seen_done;
        write_map(7'd0, 4'hC);
        clear_frame();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waited = 0;
        while (!is_sprite && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        tests++;
        if (!is_sprite) begin fails++; $display("FAIL mid_reach_plyr: is_sprite got 0 required 1 within 400 cycles"); end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, frame_done, copy_req, copy_code, base_x, base_y, is_sprite} !== '0) begin
            fails++; $display("FAIL mid_reset_outputs: got busy=%b req=%b code=%h bx=%0d by=%0d spr=%b required all 0",
                              busy, copy_req, copy_code, base_x, base_y, is_sprite);
        end
        @(negedge clock);
        reset = 1'b0;
        seen_done = 0;
        repeat (10) begin
            @(negedge clock);
            if (frame_done || busy) seen_done = 1;
        end
        tests++;
        if (seen_done) begin fails++; $display("FAIL mid_no_frame_done: frame activity got 1 required 0"); end
        run_frame();
        tests++;
        if ({r_code[0], r_bx[0], r_by[0]} !== {4'h0, 9'd72, 8'd32}) begin
            fails++; $display("FAIL mid_restart_tile0: got code=%h bx=%0d by=%0d required 0 72 32", r_code[0], r_bx[0], r_by[0]);
        end
        tests++;
        if (f_tiles !== 121 || f_cycles !== 248) begin
            fails++; $display("FAIL mid_restart_frame: got tiles=%0d cycles=%0d required 121 248", f_tiles, f_cycles);
        end
    endtask

    task automatic test_small_map();
        logic [3:0] exp_code [6];
        logic [8:0] exp_bx   [6];
        logic [7:0] exp_by   [6];
        int   cyc;
        logic prev;
        exp_code = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7};
        exp_bx   = '{9'd72, 9'd88, 9'd104, 9'd72, 9'd88, 9'd104};
        exp_by   = '{8'd32, 8'd32, 8'd32, 8'd48, 8'd48, 8'd48};
        do_reset();
        write_small(3'd0, 4'h2);
        write_small(3'd5, 4'h7);
        write_small(3'd6, 4'hF);
        clear_frame();
        @(negedge clock);
        s_start = 1'b1;
        cyc = 1; prev = 1'b0;
        while (!f_done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            s_start = 1'b0;
            if (s_copy_req && !prev) begin
                r_code.push_back(s_copy_code); r_bx.push_back(s_base_x); r_by.push_back(s_base_y);
                if (s_is_sprite) f_sprites++; else f_tiles++;
            end
            prev = s_copy_req;
            if (s_frame_done) f_done = 1;
        end
        tests++;
        if (!f_done || cyc !== 16) begin fails++; $display("FAIL small_frame_length: got %0d done=%0d required 16", cyc, f_done); end
        tests++;
        if (f_tiles !== 6 || f_sprites !== 1) begin
            fails++; $display("FAIL small_counts: got tiles=%0d sprites=%0d required 6 1", f_tiles, f_sprites);
        end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if ({r_code[k], r_bx[k], r_by[k]} !== {exp_code[k], exp_bx[k], exp_by[k]}) begin
                fails++; $display("FAIL small_tile[%0d]: got code=%h bx=%0d by=%0d required %h %0d %0d",
                                  k, r_code[k], r_bx[k], r_by[k], exp_code[k], exp_bx[k], exp_by[k]);
            end
        end
        tests++;
        if ({r_code[6], r_bx[6], r_by[6]} !== {4'h8, 9'd300, 8'd200}) begin
            fails++; $display("FAIL small_sprite: got code=%h bx=%0d by=%0d required 8 300 200", r_code[6], r_bx[6], r_by[6]);
        end
    endtask

    task automatic test_dirty();
        do_reset();
        player_alive = 2'b11;
        run_frame();
        tests++;
        if (f_tiles !== 121) begin fails++; $display("FAIL dirty_frame1_tiles: got %0d required 121", f_tiles); end
        write_map(7'd5, 4'h6);
        run_frame();
`ifdef TILE_FRAME_SEQUENCER_DIRTY_EN
        tests++;
        if (f_tiles !== 1 || f_sprites !== 2) begin
            fails++; $display("FAIL dirty_frame2_counts: got tiles=%0d sprites=%0d required 1 2", f_tiles, f_sprites);
        end
        tests++;
        if ({r_code[0], r_bx[0], r_by[0]} !== {4'h6, 9'd152, 8'd32}) begin
            fails++; $display("FAIL dirty_frame2_tile: got code=%h bx=%0d by=%0d required 6 152 32", r_code[0], r_bx[0], r_by[0]);
        end
`else
        tests++;
        if (f_tiles !== 121 || f_sprites !== 2) begin
            fails++; $display("FAIL dirty_frame2_counts: got tiles=%0d sprites=%0d required 121 2", f_tiles, f_sprites);
        end
        tests++;
        if ({r_code[5], r_bx[5], r_by[5]} !== {4'h6, 9'd152, 8'd32}) begin
            fails++; $display("FAIL dirty_frame2_tile5: got code=%h bx=%0d by=%0d required 6 152 32", r_code[5], r_bx[5], r_by[5]);
        end
`endif
        tests++;
        if (f_cycles !== 248) begin fails++; $display("FAIL dirty_frame2_length: got %0d required 248", f_cycles); end
        run_frame();
        tests++;
`ifdef TILE_FRAME_SEQUENCER_DIRTY_EN
        if (f_tiles !== 0) begin fails++; $display("FAIL dirty_frame3_tiles: got %0d required 0", f_tiles); end
`else
        if (f_tiles !== 121) begin fails++; $display("FAIL dirty_frame3_tiles: got %0d required 121", f_tiles); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_dead_player();
        test_stall();
        test_reset_mid();
        test_small_map();
        test_dirty();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
